uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one UART_TX serializer between NUM_REQ byte producers (e.g. command
//  responder, status reporter, debug echo). Round-robin grant per byte. A
//  requester can lock the transmitter across a multi-byte packet until it sends
//  its last byte. Sits between the producers and UART_TX (i_Tx_DV/i_Tx_Byte/o_Tx_Done).
// PARAMETERS
//  NUM_REQ       4    number of requesters, 2..8
//  LOCK_TIMEOUT  1024 IDLE cycles a locked owner may stall before lock is forced off; 0 = never
// PORTS
//  i_Clock          in   1          system clock, all logic on rising edge
//  i_Rst_L          in   1          asynchronous, active-low reset
//  i_Req_DV         in   NUM_REQ    per-requester byte valid; held until accepted
//  i_Req_Byte       in   NUM_REQ*8  requester k byte at [8k+7:8k]
//  i_Req_Last       in   NUM_REQ    byte is the final byte of its packet
//  o_Req_Ready      out  NUM_REQ    one-hot accept; transfer when DV&Ready at posedge
//  o_Grant          out  NUM_REQ    one-hot owner of the byte in flight or holding the lock
//  o_Tx_DV          out  1          one-cycle start pulse to UART_TX
//  o_Tx_Byte        out  8          byte to UART_TX, stable from capture until done
//  i_Tx_Done        in   1          UART_TX done pulse
//  o_Busy           out  1          state != IDLE
//  o_Lock_Timeout   out  1          one-cycle pulse when a lock is force-released
// BEHAVIOUR
//  Reset: state=IDLE; o_Req_Ready=0, o_Grant=0, o_Tx_DV=0, o_Tx_Byte=8'h00,
//   o_Busy=0, o_Lock_Timeout=0; lock=0; timeout count=0; last_grant=NUM_REQ-1,
//   so requester 0 has top priority first. Reset mid-byte abandons the byte.
//   The serializer may still finish and pulse i_Tx_Done. A done pulse seen in
//   IDLE or ISSUE is ignored.
//  FSM:
//   IDLE: lock=0 -> winner = first k with i_Req_DV[k], scanning from
//     (last_grant+1) mod NUM_REQ upward with wrap. lock=1 -> only the owner is
//     eligible. o_Req_Ready[winner] is combinational, high in this cycle only.
//     On accept: capture byte into o_Tx_Byte, last_grant<=winner,
//     o_Grant<=onehot(winner), lock<=~i_Req_Last[winner]; go to ISSUE.
//   ISSUE: o_Tx_DV=1 for exactly this cycle; go to WAIT_DONE.
//   WAIT_DONE: o_Req_Ready=0; stay until i_Tx_Done=1, then go to IDLE.
//     o_Grant is cleared on that edge unless lock=1.
//  Latency: DV high in IDLE -> Ready same cycle -> o_Tx_DV next cycle.
//   Back-to-back bytes: done -> IDLE (1 cycle, accept) -> ISSUE.
//   Inter-byte overhead is 2 clocks plus UART_TX cleanup.
//  Lock timeout: counts only in IDLE with lock=1 and owner DV=0; clears on any
//   accept. When count reaches LOCK_TIMEOUT: lock<=0, o_Grant<=0,
//   o_Lock_Timeout pulses 1 cycle, count<=0. Counter width
//   $clog2(LOCK_TIMEOUT+1). Logic is absent when LOCK_TIMEOUT=0.
//  Simultaneous events:
//   - Several DVs in one cycle: exactly one Ready.
//   - DV dropped before Ready is a protocol error; no capture occurs.
//   - A last byte releases the lock at capture, so the next IDLE is full round-robin.
//   - Owner DV and timeout expiry in the same cycle: the accept wins; no timeout pulse.
//  Single requester permanently valid: granted every byte; others never starved
//   once the lock releases (round-robin bound = NUM_REQ bytes).
// TESTING  (NUM_REQ=4, UART_TX CLKS_PER_BIT=87, 10 MHz clock)
//  1 Req0 sends 8'hAB last=1 -> Ready0 1 cycle; Tx_DV next cycle with 8'hAB;
//    serial line carries 0xAB; Busy low after done.
//  2 Req1,2,3 valid together, all last=1, bytes 11/22/33 -> TX order 11,22,33.
//    Then all four valid -> next winner is Req0 (pointer wrapped after 3).
//  3 Req2 packet 5A,5B,5C (last on 5C) while Req0 also valid -> 5A,5B,5C
//    contiguous, then Req0's byte; o_Grant=4'b0100 throughout the packet.
//  4 LOCK_TIMEOUT=16: Req3 sends 77 last=0 then drops DV; Req1 valid ->
//    o_Lock_Timeout pulses 16 cycles after return to IDLE; Req1 granted next cycle.
//  5 Assert i_Rst_L=0 mid WAIT_DONE -> all outputs zero immediately.
//    Stray Tx_Done afterwards ignored; next request is served normally,
//    starting from Req0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART_TX serializer between NUM_REQ byte producers.
// Round-robin grant per byte. A requester may lock the transmitter across a
// multi-byte packet until its last byte. An optional idle-stall timeout
// force-releases a lock held by an owner that stopped sending.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 1024
) (
   input  logic                 i_Clock,
   input  logic                 i_Rst_L,
   input  logic [NUM_REQ-1:0]   i_Req_DV,
   input  logic [NUM_REQ*8-1:0] i_Req_Byte,
   input  logic [NUM_REQ-1:0]   i_Req_Last,
   output logic [NUM_REQ-1:0]   o_Req_Ready,
   output logic [NUM_REQ-1:0]   o_Grant,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Done,
   output logic                 o_Busy,
   output logic                 o_Lock_Timeout
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_DONE
   } state_t;

   state_t             state;
   logic               lock;
   logic [IW-1:0]      last_grant;
   logic [NUM_REQ-1:0] eligible;
   logic               win_valid;
   logic [IW-1:0]      win_idx;
   logic [NUM_REQ-1:0] win_onehot;
   int                 scan_idx;
   logic               accept;
   logic               lock_expire;

   // Round-robin pick: first eligible requester after the last one served.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path leaves
      // it unassigned; a missing default here would infer a latch.
      eligible  = lock ? (i_Req_DV & o_Grant) : i_Req_DV;
      win_valid = 1'b0;
      win_idx   = '0;
      scan_idx  = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         scan_idx = (int'(last_grant) + 1 + i) % NUM_REQ;
         if (!win_valid && eligible[scan_idx]) begin
            win_valid = 1'b1;
            win_idx   = IW'(scan_idx);
         end
      end
   end

   // Ready is combinational so a byte is accepted in the same cycle DV is seen;
   // dropping DV before the edge removes Ready and nothing is captured.
   assign accept      = (state == IDLE) && win_valid;
   assign win_onehot  = NUM_REQ'(1) << win_idx;
   assign o_Req_Ready = accept ? win_onehot : '0;

   generate
      if (LOCK_TIMEOUT > 0) begin : g_timeout
         localparam int CW = $clog2(LOCK_TIMEOUT + 1);
         logic [CW-1:0] stall_cnt;
         logic          stall;

         // Owner holds the lock in IDLE but has nothing to send.
         assign stall       = (state == IDLE) && lock && !(|(i_Req_DV & o_Grant));
         assign lock_expire = stall && (stall_cnt == CW'(LOCK_TIMEOUT - 1));

         // Count stalled IDLE cycles of a locked owner; any accept restarts it.
         always_ff @(posedge i_Clock or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
               stall_cnt <= '0;
            end else if (accept || lock_expire) begin
               stall_cnt <= '0;
            end else if (stall) begin
               stall_cnt <= stall_cnt + CW'(1);
            end
         end
      end else begin : g_no_timeout
         assign lock_expire = 1'b0;
      end
   endgenerate

   // Main FSM: accept in IDLE, pulse UART_TX start in ISSUE, wait for done.
   always_ff @(posedge i_Clock or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         state          <= IDLE;
         lock           <= 1'b0;
         last_grant     <= IW'(NUM_REQ - 1);
         o_Grant        <= '0;
         o_Tx_DV        <= 1'b0;
         o_Tx_Byte      <= 8'h00;
         o_Busy         <= 1'b0;
         o_Lock_Timeout <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every register here
         // sees the values from before this edge regardless of statement order.
         o_Tx_DV        <= 1'b0;
         o_Lock_Timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  o_Tx_Byte  <= i_Req_Byte[8*win_idx +: 8];
                  last_grant <= win_idx;
                  o_Grant    <= win_onehot;
                  lock       <= ~i_Req_Last[win_idx];
                  o_Tx_DV    <= 1'b1;
                  o_Busy     <= 1'b1;
                  state      <= ISSUE;
               end else if (lock_expire) begin
                  lock           <= 1'b0;
                  o_Grant        <= '0;
                  o_Lock_Timeout <= 1'b1;
               end
            end
            ISSUE: begin
               state <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (i_Tx_Done) begin
                  state  <= IDLE;
                  o_Busy <= 1'b0;
                  if (!lock) begin
                     o_Grant <= '0;
                  end
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized producer traffic,
// checked every cycle against a transaction-level model of the arbiter.
module tb_uart_tx_arbiter;

   localparam int NUM_REQ = 4;
   localparam int LT      = 16;

   logic                 i_Clock = 1'b0;
   logic                 i_Rst_L;
   logic [NUM_REQ-1:0]   i_Req_DV;
   logic [NUM_REQ*8-1:0] i_Req_Byte;
   logic [NUM_REQ-1:0]   i_Req_Last;
   logic [NUM_REQ-1:0]   o_Req_Ready;
   logic [NUM_REQ-1:0]   o_Grant;
   logic                 o_Tx_DV;
   logic [7:0]           o_Tx_Byte;
   logic                 i_Tx_Done;
   logic                 o_Busy;
   logic                 o_Lock_Timeout;

   uart_tx_arbiter #(
      .NUM_REQ      (NUM_REQ),
      .LOCK_TIMEOUT (LT)
   ) dut (
      .i_Clock        (i_Clock),
      .i_Rst_L        (i_Rst_L),
      .i_Req_DV       (i_Req_DV),
      .i_Req_Byte     (i_Req_Byte),
      .i_Req_Last     (i_Req_Last),
      .o_Req_Ready    (o_Req_Ready),
      .o_Grant        (o_Grant),
      .o_Tx_DV        (o_Tx_DV),
      .o_Tx_Byte      (o_Tx_Byte),
      .i_Tx_Done      (i_Tx_Done),
      .o_Busy         (o_Busy),
      .o_Lock_Timeout (o_Lock_Timeout)
   );

   always #5 i_Clock = ~i_Clock;

   int n_checks = 0;
   int n_fail   = 0;

   // Producer queues: {last, byte}; DV is held while a queue is non-empty.
   logic [8:0] rq [NUM_REQ][$];
   logic [7:0] tx_log [$];
   logic [7:0] exp_q [$];

   // Transaction-level model state.
   int                 m_last;
   bit                 m_lock;
   int                 m_owner;
   bit                 m_free;
   bit                 m_issue;
   logic [7:0]         m_byte;
   logic [NUM_REQ-1:0] m_grant;
   int                 m_stall;
   bit                 m_pulse;
   int                 done_cnt;
   bit                 force_done;
   int                 cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_last     = NUM_REQ - 1;
      m_lock     = 1'b0;
      m_owner    = 0;
      m_free     = 1'b1;
      m_issue    = 1'b0;
      m_byte     = 8'h00;
      m_grant    = '0;
      m_stall    = 0;
      m_pulse    = 1'b0;
      done_cnt   = 0;
      force_done = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) rq[k].delete();
   endtask

   function automatic bit queues_empty();
      for (int k = 0; k < NUM_REQ; k++) if (rq[k].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic push(input int k, input logic [7:0] b, input bit last);
      rq[k].push_back({last, b});
   endtask

   // One clock: drive producers and serializer done, then check at negedge.
   task automatic step();
      int                 win;
      logic [NUM_REQ-1:0] exp_ready;
      bit                 exp_issue;
      bit                 exp_pulse;
      bit                 was_free;
      @(posedge i_Clock);
      #1;
      cyc++;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (rq[k].size() > 0) begin
            i_Req_DV[k]          = 1'b1;
            i_Req_Byte[8*k +: 8] = rq[k][0][7:0];
            i_Req_Last[k]        = rq[k][0][8];
         end else begin
            i_Req_DV[k]          = 1'b0;
            i_Req_Byte[8*k +: 8] = 8'($urandom);
            i_Req_Last[k]        = 1'($urandom);
         end
      end
      i_Tx_Done = 1'b0;
      if (force_done) begin
         i_Tx_Done  = 1'b1;
         force_done = 1'b0;
      end else if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) i_Tx_Done = 1'b1;
      end
      @(negedge i_Clock);
      // Expected winner: nearest valid requester after the last one served,
      // restricted to the owner while a packet lock is held.
      win       = -1;
      exp_ready = '0;
      if (m_free) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            int k = (m_last + 1 + i) % NUM_REQ;
            if (win < 0 && i_Req_DV[k] && (!m_lock || k == m_owner)) win = k;
         end
      end
      if (win >= 0) exp_ready[win] = 1'b1;
      exp_issue = m_issue;
      exp_pulse = m_pulse;
      was_free  = m_free;
      check("ready", 32'(o_Req_Ready), 32'(exp_ready));
      check("tx_dv", 32'(o_Tx_DV), 32'(exp_issue));
      check("busy", 32'(o_Busy), 32'(!m_free));
      check("grant", 32'(o_Grant), 32'(m_grant));
      check("lock_timeout", 32'(o_Lock_Timeout), 32'(exp_pulse));
      if (!m_free) check("tx_byte", 32'(o_Tx_Byte), 32'(m_byte));
      if (o_Tx_DV) begin
         tx_log.push_back(o_Tx_Byte);
         done_cnt = $urandom_range(1, 6);
      end
      m_issue = 1'b0;
      m_pulse = 1'b0;
      if (win >= 0) begin
         m_issue = 1'b1;
         m_byte  = rq[win][0][7:0];
         m_lock  = !rq[win][0][8];
         m_owner = win;
         m_last  = win;
         m_grant = '0;
         m_grant[win] = 1'b1;
         m_free  = 1'b0;
         m_stall = 0;
         void'(rq[win].pop_front());
      end else if (m_free && m_lock && !i_Req_DV[m_owner]) begin
         m_stall++;
         if (m_stall == LT) begin
            m_lock  = 1'b0;
            m_grant = '0;
            m_stall = 0;
            m_pulse = 1'b1;
         end
      end
      if (i_Tx_Done && !was_free && !exp_issue) begin
         m_free = 1'b1;
         if (!m_lock) m_grant = '0;
      end
   endtask

   task automatic run_until_idle(input string tag, input int max_cycles);
      int n = 0;
      while (!(queues_empty() && m_free && !m_issue && done_cnt == 0) && n < max_cycles) begin
         step();
         n++;
      end
      check({tag, "_drained"}, 32'(queues_empty() && m_free && done_cnt == 0), 32'(1));
   endtask

   task automatic check_log(input string tag);
      check({tag, "_len"}, 32'(tx_log.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
         check({tag, "_byte"}, 32'(tx_log[i]), 32'(exp_q[i]));
      tx_log.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t_idle;
      int t_pulse;
      logic [NUM_REQ-1:0] g_after;

      i_Rst_L    = 1'b0;
      i_Req_DV   = '0;
      i_Req_Byte = '0;
      i_Req_Last = '0;
      i_Tx_Done  = 1'b0;
      model_reset();
      repeat (3) @(posedge i_Clock);
      @(negedge i_Clock);
      check("rst_ready", 32'(o_Req_Ready), 32'(0));
      check("rst_grant", 32'(o_Grant), 32'(0));
      check("rst_tx_dv", 32'(o_Tx_DV), 32'(0));
      check("rst_tx_byte", 32'(o_Tx_Byte), 32'(0));
      check("rst_busy", 32'(o_Busy), 32'(0));
      check("rst_lock_timeout", 32'(o_Lock_Timeout), 32'(0));
      i_Rst_L = 1'b1;

      // 1: single byte from Req0.
      push(0, 8'hAB, 1'b1);
      run_until_idle("t1", 100);
      exp_q = {8'hAB};
      check_log("t1_order");

      // 2: three simultaneous requesters, then all four.
      push(1, 8'h11, 1'b1);
      push(2, 8'h22, 1'b1);
      push(3, 8'h33, 1'b1);
      run_until_idle("t2a", 200);
      exp_q = {8'h11, 8'h22, 8'h33};
      check_log("t2a_order");
      for (int k = 0; k < NUM_REQ; k++) push(k, 8'hA0 + 8'(k), 1'b1);
      run_until_idle("t2b", 200);
      exp_q = {8'hA0, 8'hA1, 8'hA2, 8'hA3};
      check_log("t2b_order");

      // 3: locked packet from Req2 is not interrupted by Req0.
      push(2, 8'h5A, 1'b0);
      push(2, 8'h5B, 1'b0);
      push(2, 8'h5C, 1'b1);
      step();
      push(0, 8'hC0, 1'b1);
      run_until_idle("t3", 200);
      exp_q = {8'h5A, 8'h5B, 8'h5C, 8'hC0};
      check_log("t3_order");

      // 4: Req3 abandons its packet; lock times out, then Req1 is served.
      push(3, 8'h77, 1'b0);
      step();
      push(1, 8'h99, 1'b1);
      t_idle  = -1;
      t_pulse = -1;
      g_after = '0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (t_idle < 0 && !o_Busy) t_idle = cyc;
         if (t_pulse >= 0 && cyc == t_pulse + 1) g_after = o_Grant;
         if (t_pulse < 0 && o_Lock_Timeout) t_pulse = cyc;
      end
      check("t4_timeout_delay", 32'(t_pulse - t_idle), 32'(LT));
      check("t4_grant_after", 32'(g_after), 32'(4'b0010));
      run_until_idle("t4", 200);
      exp_q = {8'h77, 8'h99};
      check_log("t4_order");

      // 5: reset in the middle of WAIT_DONE.
      push(0, 8'hE5, 1'b1);
      repeat (3) step();
      check("t5_busy_before", 32'(o_Busy), 32'(1));
      i_Rst_L = 1'b0;
      #1;
      check("t5_rst_ready", 32'(o_Req_Ready), 32'(0));
      check("t5_rst_grant", 32'(o_Grant), 32'(0));
      check("t5_rst_tx_dv", 32'(o_Tx_DV), 32'(0));
      check("t5_rst_tx_byte", 32'(o_Tx_Byte), 32'(0));
      check("t5_rst_busy", 32'(o_Busy), 32'(0));
      check("t5_rst_lock_timeout", 32'(o_Lock_Timeout), 32'(0));
      model_reset();
      tx_log.delete();
      i_Tx_Done = 1'b0;
      i_Req_DV  = '0;
      @(posedge i_Clock);
      @(negedge i_Clock);
      i_Rst_L    = 1'b1;
      force_done = 1'b1;
      step();
      push(1, 8'hE1, 1'b1);
      push(0, 8'hE0, 1'b1);
      run_until_idle("t5", 200);
      exp_q = {8'hE0, 8'hE1};
      check_log("t5_order");

      // Random traffic: packets of 1..3 bytes, some truncated to provoke timeouts.
      for (int c = 0; c < 800; c++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (rq[k].size() == 0 && $urandom_range(0, 9) == 0) begin
               int len  = $urandom_range(1, 3);
               bit trnc = ($urandom_range(0, 7) == 0);
               for (int j = 0; j < len; j++) push(k, 8'($urandom), (j == len - 1) && !trnc);
            end
         end
         step();
      end
      run_until_idle("rand", 5000);
      tx_log.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
